// File: rtl/serial_flag_alu_if.sv
// Request/response bundle between control and the serial flag-setting ALU.
interface serial_flag_alu_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  start;
    logic [3:0]            op;
    logic                  set_flags;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic                  negative;
    logic                  zero;
    logic                  carry;
    logic                  overflow;
    logic                  update_sreg;

    modport master (
        output start, op, set_flags, a, b,
        input  busy, done, result, negative, zero, carry, overflow, update_sreg
    );

    modport slave (
        input  start, op, set_flags, a, b,
        output busy, done, result, negative, zero, carry, overflow, update_sreg
    );
endinterface

// File: rtl/serial_flag_alu.sv
// Multi-cycle ALU: one SLICE_WIDTH slice per clock, LSB first, rippled carry, NZCV output.
module serial_flag_alu #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned SLICE_WIDTH = 16
) (
    input logic              clk,
    input logic              reset,
    serial_flag_alu_if.slave bus
);
    localparam int unsigned N_SLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int unsigned CNT_W    = $clog2(N_SLICES + 1);
    // Counter runs one past the last slice; that extra cycle commits result and flags.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SLICES);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_ORR   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0]  a_q, b_q, acc_q, result_q;
    logic [3:0]             op_q;
    logic                   sf_q, carry_q, a_msb_q, b_msb_q;
    logic [N_SLICES-1:0]    zslice_q;
    logic                   neg_q, zero_q, carry_flag_q, ovf_q;

    logic [SLICE_WIDTH-1:0] a_sl, b_sl, slice_res;
    logic [SLICE_WIDTH:0]   slice_sum;
    logic                   slice_cout, is_arith;
    logic [DATA_WIDTH+SLICE_WIDTH-1:0] acc_shift;
    logic [N_SLICES:0]                 zslice_shift;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is ignored outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (cnt_q == LAST_CNT) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.busy        = (state_q != StIdle);
        bus.done        = (state_q == StDone);
        bus.update_sreg = (state_q == StDone) && sf_q;
    end

    // One-slice datapath; b_q is already inverted for SUB.
    always_comb begin
        a_sl       = a_q[SLICE_WIDTH-1:0];
        b_sl       = b_q[SLICE_WIDTH-1:0];
        slice_sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_WIDTH{1'b0}}, carry_q};
        slice_res  = '0;
        slice_cout = 1'b0;
        case (op_q)
            OP_AND:         slice_res = a_sl & b_sl;
            OP_ORR:         slice_res = a_sl | b_sl;
            OP_ADD, OP_SUB: {slice_cout, slice_res} = slice_sum;
            OP_PASSB:       slice_res = b_sl;
            OP_NOR:         slice_res = ~(a_sl | b_sl);
            default:        slice_res = '0;
        endcase
        is_arith     = (op_q == OP_ADD) || (op_q == OP_SUB);
        acc_shift    = {slice_res, acc_q};
        zslice_shift = {(slice_res == '0), zslice_q};
    end

    // Operand capture, slice sequencing and result/flag commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            op_q         <= '0;
            sf_q         <= 1'b0;
            carry_q      <= 1'b0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            zslice_q     <= '0;
            result_q     <= '0;
            neg_q        <= 1'b0;
            zero_q       <= 1'b0;
            carry_flag_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else if (state_q == StIdle) begin
            if (bus.start) begin
                a_q      <= bus.a;
                b_q      <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                op_q     <= bus.op;
                sf_q     <= bus.set_flags;
                carry_q  <= (bus.op == OP_SUB);
                a_msb_q  <= bus.a[DATA_WIDTH-1];
                b_msb_q  <= (bus.op == OP_SUB) ? ~bus.b[DATA_WIDTH-1] : bus.b[DATA_WIDTH-1];
                cnt_q    <= '0;
                zslice_q <= '0;
            end
        end else if (state_q == StRun) begin
            if (cnt_q != LAST_CNT) begin
                // Slices enter at the top so the accumulator ends up in natural bit order.
                a_q      <= a_q >> SLICE_WIDTH;
                b_q      <= b_q >> SLICE_WIDTH;
                acc_q    <= acc_shift[DATA_WIDTH+SLICE_WIDTH-1:SLICE_WIDTH];
                zslice_q <= zslice_shift[N_SLICES:1];
                carry_q  <= slice_cout;
                cnt_q    <= cnt_q + CNT_W'(1);
            end else begin
                result_q <= acc_q;
                if (sf_q) begin
                    neg_q        <= acc_q[DATA_WIDTH-1];
                    zero_q       <= &zslice_q;
                    carry_flag_q <= is_arith && carry_q;
                    ovf_q        <= is_arith && (a_msb_q == b_msb_q)
                                    && (acc_q[DATA_WIDTH-1] != a_msb_q);
                end
            end
        end
    end

    // Held result and flags.
    always_comb begin
        bus.result   = result_q;
        bus.negative = neg_q;
        bus.zero     = zero_q;
        bus.carry    = carry_flag_q;
        bus.overflow = ovf_q;
    end
endmodule
